// File: rtl/universal_shift_reg.sv
// universal_shift_reg
//   WIDTH-bit synchronous register with hold, logical shift left/right,
//   arithmetic shift right, rotate left/right, parallel load and clear.
//
// Parameters
//   WIDTH    register width in bits (>= 2)
//   RST_VAL  value loaded into Q on reset and by the CLR mode
//
// Ports
//   clk   rising-edge clock
//   rst   synchronous active-high reset (priority over CE and MODE)
//   CE    clock enable; 0 holds Q and SO regardless of MODE
//   MODE  operation select (HOLD/SHL/SHR/ASR/ROL/ROR/LOAD/CLR)
//   SI    serial input for the logical shifts
//   D     parallel load data
//   Q     register contents
//   Qbar  bitwise complement of Q
//   SO    bit shifted or rotated out by the last executed shift/rotate
//   ZERO  high when Q is all zeros
module universal_shift_reg #(
   parameter int unsigned            WIDTH   = 8,
   parameter logic [WIDTH-1:0]       RST_VAL = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             CE,
   input  logic [2:0]       MODE,
   input  logic             SI,
   input  logic [WIDTH-1:0] D,
   output logic [WIDTH-1:0] Q,
   output logic [WIDTH-1:0] Qbar,
   output logic             SO,
   output logic             ZERO
);

   typedef enum logic [2:0] {
      M_HOLD = 3'b000,
      M_SHL  = 3'b001,
      M_SHR  = 3'b010,
      M_ASR  = 3'b011,
      M_ROL  = 3'b100,
      M_ROR  = 3'b101,
      M_LOAD = 3'b110,
      M_CLR  = 3'b111
   } mode_t;

   mode_t mode;
   assign mode = mode_t'(MODE);

   always_ff @(posedge clk) begin
      if (rst) begin
         Q  <= RST_VAL;
         SO <= 1'b0;
      end else if (CE) begin
         case (mode)
            M_HOLD: ;
            M_SHL: begin
               Q  <= {Q[WIDTH-2:0], SI};
               SO <= Q[WIDTH-1];
            end
            M_SHR: begin
               Q  <= {SI, Q[WIDTH-1:1]};
               SO <= Q[0];
            end
            M_ASR: begin
               Q  <= {Q[WIDTH-1], Q[WIDTH-1:1]};
               SO <= Q[0];
            end
            M_ROL: begin
               Q  <= {Q[WIDTH-2:0], Q[WIDTH-1]};
               SO <= Q[WIDTH-1];
            end
            M_ROR: begin
               Q  <= {Q[0], Q[WIDTH-1:1]};
               SO <= Q[0];
            end
            M_LOAD: Q <= D;
            M_CLR: begin
               Q  <= RST_VAL;
               SO <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   // Derived from Q itself so neither output can disagree with the stored word.
   assign Qbar = ~Q;
   assign ZERO = (Q == '0);

endmodule

// File: tb/tb_universal_shift_reg.sv
module tb_universal_shift_reg;

   logic        clk = 1'b0;
   logic        rst, ce, si;
   logic [2:0]  mode;
   logic [31:0] d32;
   logic [7:0]  d8;
   logic [1:0]  d2;

   logic [7:0]  q8, qb8;
   logic [1:0]  q2, qb2;
   logic [31:0] q32, qb32;
   logic        so8, so2, so32, z8, z2, z32;

   int vecs = 0;
   int errs = 0;

   longint unsigned m8 = 0, m2 = 0, m32 = 0;
   bit mso8 = 0, mso2 = 0, mso32 = 0;

   localparam logic [7:0]  RV8  = 8'hA5;
   localparam logic [1:0]  RV2  = 2'b10;
   localparam logic [31:0] RV32 = 32'hDEAD_BEEF;

   always #5 clk = ~clk;

   universal_shift_reg #(.WIDTH(8), .RST_VAL(RV8)) dut8 (
      .clk(clk), .rst(rst), .CE(ce), .MODE(mode), .SI(si), .D(d8),
      .Q(q8), .Qbar(qb8), .SO(so8), .ZERO(z8));

   universal_shift_reg #(.WIDTH(2), .RST_VAL(RV2)) dut2 (
      .clk(clk), .rst(rst), .CE(ce), .MODE(mode), .SI(si), .D(d2),
      .Q(q2), .Qbar(qb2), .SO(so2), .ZERO(z2));

   universal_shift_reg #(.WIDTH(32), .RST_VAL(RV32)) dut32 (
      .clk(clk), .rst(rst), .CE(ce), .MODE(mode), .SI(si), .D(d32),
      .Q(q32), .Qbar(qb32), .SO(so32), .ZERO(z32));

   // Reference: operations expressed as integer arithmetic on a w-bit word.
   function automatic longint unsigned nxt(input int w, input longint unsigned q,
                                           input bit so_i, input bit r, input bit c,
                                           input bit [2:0] m, input bit s,
                                           input longint unsigned d, input longint unsigned rv,
                                           output bit so_o);
      longint unsigned mask, top;
      bit msb, lsb;
      mask = (64'd1 << w) - 64'd1;
      top  = 64'd1 << (w - 1);
      msb  = (q & top) != 0;
      lsb  = q[0];
      so_o = so_i;
      if (r) begin so_o = 1'b0; return rv & mask; end
      if (!c) return q;
      case (m)
         3'd1: begin so_o = msb; return ((q * 2) + 64'(s)) & mask; end
         3'd2: begin so_o = lsb; return (q / 2) + (s ? top : 64'd0); end
         3'd3: begin so_o = lsb; return (q / 2) + (msb ? top : 64'd0); end
         3'd4: begin so_o = msb; return ((q * 2) + 64'(msb)) & mask; end
         3'd5: begin so_o = lsb; return (q / 2) + (lsb ? top : 64'd0); end
         3'd6: return d & mask;
         3'd7: begin so_o = 1'b0; return rv & mask; end
         default: return q;
      endcase
   endfunction

   // Drive one edge's inputs, advance the models, and check every instance
   // against its model plus the Qbar/ZERO invariants.
   task automatic apply(input bit r, input bit c, input bit [2:0] m, input bit s,
                        input logic [31:0] dv);
      bit so_n;
      rst = r; ce = c; mode = m; si = s; d32 = dv; d8 = dv[7:0]; d2 = dv[1:0];
      @(posedge clk);
      m8  = nxt(8,  m8,  mso8,  r, c, m, s, 64'(dv[7:0]), 64'(RV8),  so_n); mso8  = so_n;
      m2  = nxt(2,  m2,  mso2,  r, c, m, s, 64'(dv[1:0]), 64'(RV2),  so_n); mso2  = so_n;
      m32 = nxt(32, m32, mso32, r, c, m, s, 64'(dv),      64'(RV32), so_n); mso32 = so_n;
      @(negedge clk);
      vecs++;
      if (q8 !== 8'(m8) || so8 !== mso8) begin
         errs++;
         $display("FAIL model_w8 mode=%0d got q=%h so=%b exp q=%h so=%b", m, q8, so8, 8'(m8), mso8);
      end
      vecs++;
      if (q2 !== 2'(m2) || so2 !== mso2) begin
         errs++;
         $display("FAIL model_w2 mode=%0d got q=%b so=%b exp q=%b so=%b", m, q2, so2, 2'(m2), mso2);
      end
      vecs++;
      if (q32 !== 32'(m32) || so32 !== mso32) begin
         errs++;
         $display("FAIL model_w32 mode=%0d got q=%h so=%b exp q=%h so=%b", m, q32, so32, 32'(m32), mso32);
      end
      vecs++;
      if (qb8 !== ~q8 || z8 !== (q8 == 8'h00) || qb2 !== ~q2 || z2 !== (q2 == 2'b00) ||
          qb32 !== ~q32 || z32 !== (q32 == 32'h0)) begin
         errs++;
         $display("FAIL invariants got qb8=%h z8=%b qb2=%b z2=%b qb32=%h z32=%b for q8=%h q2=%b q32=%h",
                  qb8, z8, qb2, z2, qb32, z32, q8, q2, q32);
      end
   endtask

   task automatic test_reset;
      apply(1, 1, 3'd1, 1, 32'h0);
      apply(1, 0, 3'd6, 0, 32'hFFFF_FFFF);
      vecs++;
      if (q8 !== 8'hA5 || qb8 !== 8'h5A || so8 !== 1'b0 || z8 !== 1'b0) begin
         errs++;
         $display("FAIL reset got q=%h qbar=%h so=%b zero=%b exp q=a5 qbar=5a so=0 zero=0", q8, qb8, so8, z8);
      end
      apply(0, 1, 3'd7, 1, 32'h1234_5678);
      vecs++;
      if (q8 !== 8'hA5 || so8 !== 1'b0) begin
         errs++;
         $display("FAIL clr got q=%h so=%b exp q=a5 so=0", q8, so8);
      end
   endtask

   task automatic test_load_hold;
      bit so_before;
      // Inputs change mid-cycle: Q must not follow D before the edge.
      rst = 0; ce = 1; mode = 3'd6; si = 0; d32 = 32'h3C; d8 = 8'h3C; d2 = 2'b00;
      #2;
      vecs++;
      if (q8 !== 8'hA5) begin
         errs++;
         $display("FAIL no_transparency got q=%h exp q=a5", q8);
      end
      apply(0, 1, 3'd6, 0, 32'h0000_003C);
      vecs++;
      if (q8 !== 8'h3C) begin
         errs++;
         $display("FAIL load got q=%h exp q=3c", q8);
      end
      so_before = so8;
      for (int i = 0; i < 3; i++) apply(0, 0, 3'd1, 1, 32'hFFFF_FFFF);
      vecs++;
      if (q8 !== 8'h3C || so8 !== so_before) begin
         errs++;
         $display("FAIL ce_hold got q=%h so=%b exp q=3c so=%b", q8, so8, so_before);
      end
   endtask

   task automatic test_shift;
      apply(0, 1, 3'd6, 0, 32'h81);
      apply(0, 1, 3'd1, 0, 32'h0);
      vecs++;
      if (q8 !== 8'h02 || so8 !== 1'b1) begin
         errs++;
         $display("FAIL shl got q=%h so=%b exp q=02 so=1", q8, so8);
      end
      apply(0, 1, 3'd2, 1, 32'h0);
      vecs++;
      if (q8 !== 8'h81 || so8 !== 1'b0) begin
         errs++;
         $display("FAIL shr got q=%h so=%b exp q=81 so=0", q8, so8);
      end
      apply(0, 1, 3'd6, 0, 32'hFFFF_FFFF);
      for (int i = 0; i < 8; i++) apply(0, 1, 3'd1, 0, 32'h0);
      vecs++;
      if (q8 !== 8'h00 || z8 !== 1'b1) begin
         errs++;
         $display("FAIL shl_flush got q=%h zero=%b exp q=00 zero=1", q8, z8);
      end
   endtask

   task automatic test_asr_rotate;
      apply(0, 1, 3'd6, 0, 32'h8000_0090);
      apply(0, 1, 3'd3, 1, 32'h0);
      vecs++;
      if (q8 !== 8'hC8 || so8 !== 1'b0) begin
         errs++;
         $display("FAIL asr got q=%h so=%b exp q=c8 so=0", q8, so8);
      end
      for (int i = 0; i < 31; i++) apply(0, 1, 3'd3, 0, 32'h0);
      vecs++;
      if (q8 !== 8'hFF || q32 !== 32'hFFFF_FFFF || q2 !== 2'b00) begin
         errs++;
         $display("FAIL asr_saturate got q8=%h q32=%h q2=%b exp ff ffffffff 00", q8, q32, q2);
      end
      apply(0, 1, 3'd6, 0, 32'h4000_0081);
      apply(0, 1, 3'd4, 0, 32'h0);
      vecs++;
      if (q8 !== 8'h03 || so8 !== 1'b1 || q32 !== 32'h8000_0102 || q2 !== 2'b10) begin
         errs++;
         $display("FAIL rol got q8=%h so8=%b q32=%h q2=%b exp 03 1 80000102 10", q8, so8, q32, q2);
      end
      for (int i = 0; i < 8; i++) apply(0, 1, 3'd5, 0, 32'h0);
      vecs++;
      if (q8 !== 8'h03 || q2 !== 2'b10) begin
         errs++;
         $display("FAIL ror_cycle got q8=%h q2=%b exp 03 10", q8, q2);
      end
      for (int i = 0; i < 24; i++) apply(0, 1, 3'd5, 0, 32'h0);
      vecs++;
      if (q32 !== 32'h8000_0102) begin
         errs++;
         $display("FAIL ror_cycle_w32 got q=%h exp 80000102", q32);
      end
   endtask

   task automatic test_reset_mid;
      apply(0, 1, 3'd6, 0, 32'h1);
      apply(0, 1, 3'd4, 0, 32'h0);
      apply(0, 1, 3'd4, 0, 32'h0);
      apply(1, 1, 3'd4, 0, 32'h0);
      vecs++;
      if (q8 !== 8'hA5 || so8 !== 1'b0) begin
         errs++;
         $display("FAIL reset_mid got q=%h so=%b exp q=a5 so=0", q8, so8);
      end
      apply(0, 1, 3'd4, 0, 32'h0);
      vecs++;
      if (q8 !== 8'h4B || so8 !== 1'b1) begin
         errs++;
         $display("FAIL rol_after_reset got q=%h so=%b exp q=4b so=1", q8, so8);
      end
   endtask

   task automatic test_random;
      for (int i = 0; i < 400; i++) begin
         apply(($urandom_range(0, 31) == 0), ($urandom_range(0, 4) != 0),
               3'($urandom_range(0, 7)), 1'($urandom), $urandom);
      end
   endtask

   initial begin
      rst = 1; ce = 0; mode = 3'd0; si = 0; d32 = '0; d8 = '0; d2 = '0;
      @(negedge clk);
      test_reset;
      test_load_hold;
      test_shift;
      test_asr_rotate;
      test_reset_mid;
      test_random;
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
